// File: rtl/timer_pkg.sv
// Shared encodings for the timer/event counter block.
package timer_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'd0;
  localparam logic [1:0] MODE_SAT     = 2'd1;
  localparam logic [1:0] MODE_ONESHOT = 2'd2;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Rate divider: asserts tick on every (prescale+1)-th advancing cycle.
module timer_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  advance,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] p_q, p_d;

  // Equality compare: if prescale drops below p, p runs through its wrap first.
  assign tick = advance && (p_q == prescale);

  always_comb begin
    // NOTE: default first so every path assigns p_d and no latch is inferred.
    p_d = p_q;
    if (clr) begin
      p_d = '0;
    end else if (advance) begin
      p_d = tick ? '0 : p_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments for all registered state.
    if (reset) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

endmodule

// File: rtl/timer_counter.sv
// Up/down timer with prescaler, terminal limit and wrap/saturate/one-shot modes.
module timer_counter
  import timer_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  input  logic                  up,
  input  logic [1:0]            mode,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  overflow,
  output logic                  running
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  state_e           state_q, state_d;
  logic             tick;
  logic             terminal;

  timer_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clock   (clock),
    .reset   (reset),
    .clr     (clear | load),
    .advance (enable & running),
    .prescale(prescale),
    .tick    (tick)
  );

  // Up uses >= so a load or limit change above the count still terminates.
  assign terminal = up ? (count_q >= limit) : (count_q == '0);

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    state_d = state_q;
    if (clear) begin
      count_d = '0;
      ovf_d   = 1'b0;
      state_d = ST_RUN;
    end else if (load) begin
      count_d = load_value;
      state_d = ST_RUN;
    end else if (tick) begin
      if (terminal) begin
        tc_d  = 1'b1;
        ovf_d = 1'b1;
        case (mode)
          MODE_SAT:     count_d = count_q;
          MODE_ONESHOT: state_d = ST_HALTED;
          default:      count_d = up ? '0 : limit;
        endcase
      end else begin
        count_d = up ? count_q + 1'b1 : count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      state_q <= ST_RUN;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
    end
  end

  assign count    = count_q;
  assign tc       = tc_q;
  assign overflow = ovf_q;
  assign running  = (state_q == ST_RUN);

endmodule

// File: tb/tb_timer_counter.sv
// Vector table plus hand-written corner sequences, compared through an expectation queue.
module tb_timer_counter;
  import timer_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        clear = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_value = '0;
  logic        up = 1'b1;
  logic [1:0]  mode = MODE_WRAP;
  logic [15:0] limit = '0;
  logic [7:0]  prescale = '0;
  logic [15:0] count;
  logic        tc;
  logic        overflow;
  logic        running;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst, clr, ld, en, up;
    logic [1:0]  mode;
    logic [15:0] ldv, lim;
    logic [7:0]  ps;
    logic [15:0] e_count;
    logic        e_tc, e_ovf, e_run;
  } vec_t;

  vec_t vec_q[$];
  vec_t exp_q[$];
  int   vec_no = 0;

  timer_counter #(.WIDTH(16), .PRESCALE_W(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .clear     (clear),
    .load      (load),
    .load_value(load_value),
    .up        (up),
    .mode      (mode),
    .limit     (limit),
    .prescale  (prescale),
    .count     (count),
    .tc        (tc),
    .overflow  (overflow),
    .running   (running)
  );

  always #5 clock = ~clock;

  function automatic vec_t v(logic rst, logic clr, logic ld, logic [15:0] ldv, logic en,
                             logic u, logic [1:0] m, logic [15:0] lim, logic [7:0] ps,
                             logic [15:0] e_count, logic e_tc, logic e_ovf, logic e_run);
    vec_t r;
    r.rst = rst; r.clr = clr; r.ld = ld; r.ldv = ldv; r.en = en; r.up = u;
    r.mode = m; r.lim = lim; r.ps = ps;
    r.e_count = e_count; r.e_tc = e_tc; r.e_ovf = e_ovf; r.e_run = e_run;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic apply(input vec_t s);
    vec_t e;
    @(negedge clock);
    reset = s.rst; clear = s.clr; load = s.ld; load_value = s.ldv;
    enable = s.en; up = s.up; mode = s.mode; limit = s.lim; prescale = s.ps;
    exp_q.push_back(s);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check($sformatf("v%0d.count", vec_no), 32'(count), 32'(e.e_count));
    check($sformatf("v%0d.tc", vec_no), 32'(tc), 32'(e.e_tc));
    check($sformatf("v%0d.overflow", vec_no), 32'(overflow), 32'(e.e_ovf));
    check($sformatf("v%0d.running", vec_no), 32'(running), 32'(e.e_run));
    vec_no++;
  endtask

  initial begin
    int down_seq[11] = '{3, 3, 2, 2, 2, 1, 1, 1, 0, 0, 0};

    // Basic up-count, WRAP, limit 5
    vec_q.push_back(v(1,0,0,0,0,1,MODE_WRAP,5,0, 0,0,0,1));
    vec_q.push_back(v(1,0,0,0,0,1,MODE_WRAP,5,0, 0,0,0,1));
    for (int i = 1; i <= 5; i++) vec_q.push_back(v(0,0,0,0,1,1,MODE_WRAP,5,0, 16'(i),0,0,1));
    vec_q.push_back(v(0,0,0,0,1,1,MODE_WRAP,5,0, 0,1,1,1));
    vec_q.push_back(v(0,0,0,0,1,1,MODE_WRAP,5,0, 1,0,1,1));

    // Prescaled down-count from 3, reload to 9, enable gap with p held at 1
    vec_q.push_back(v(0,1,0,0,0,0,MODE_WRAP,9,2, 0,0,0,1));
    vec_q.push_back(v(0,0,1,3,1,0,MODE_WRAP,9,2, 3,0,0,1));
    for (int i = 0; i < 11; i++) vec_q.push_back(v(0,0,0,0,1,0,MODE_WRAP,9,2, 16'(down_seq[i]),0,0,1));
    vec_q.push_back(v(0,0,0,0,1,0,MODE_WRAP,9,2, 9,1,1,1));
    vec_q.push_back(v(0,0,0,0,1,0,MODE_WRAP,9,2, 9,0,1,1));
    for (int i = 0; i < 4; i++) vec_q.push_back(v(0,0,0,0,0,0,MODE_WRAP,9,2, 9,0,1,1));
    vec_q.push_back(v(0,0,0,0,1,0,MODE_WRAP,9,2, 9,0,1,1));
    vec_q.push_back(v(0,0,0,0,1,0,MODE_WRAP,9,2, 8,0,1,1));

    // Saturate at 3 with repeated tc
    vec_q.push_back(v(0,1,0,0,0,1,MODE_SAT,3,0, 0,0,0,1));
    for (int i = 1; i <= 3; i++) vec_q.push_back(v(0,0,0,0,1,1,MODE_SAT,3,0, 16'(i),0,0,1));
    for (int i = 0; i < 3; i++) vec_q.push_back(v(0,0,0,0,1,1,MODE_SAT,3,0, 3,1,1,1));

    // Reserved mode behaves as WRAP
    vec_q.push_back(v(0,1,0,0,0,1,2'd3,1,0, 0,0,0,1));
    vec_q.push_back(v(0,0,0,0,1,1,2'd3,1,0, 1,0,0,1));
    vec_q.push_back(v(0,0,0,0,1,1,2'd3,1,0, 0,1,1,1));
    vec_q.push_back(v(0,0,0,0,1,1,2'd3,1,0, 1,0,1,1));

    // One-shot to 2
    vec_q.push_back(v(0,1,0,0,0,1,MODE_ONESHOT,2,0, 0,0,0,1));
    vec_q.push_back(v(0,0,0,0,1,1,MODE_ONESHOT,2,0, 1,0,0,1));
    vec_q.push_back(v(0,0,0,0,1,1,MODE_ONESHOT,2,0, 2,0,0,1));
    vec_q.push_back(v(0,0,0,0,1,1,MODE_ONESHOT,2,0, 2,1,1,0));

    foreach (vec_q[i]) apply(vec_q[i]);

    // One-shot stays halted for many enabled cycles, then load restarts it
    for (int i = 0; i < 12; i++) apply(v(0,0,0,0,1,1,MODE_ONESHOT,2,0, 2,0,1,0));
    apply(v(0,0,1,0,1,1,MODE_ONESHOT,2,0, 0,0,1,1));
    apply(v(0,0,0,0,1,1,MODE_ONESHOT,2,0, 1,0,1,1));
    apply(v(0,0,0,0,1,1,MODE_ONESHOT,2,0, 2,0,1,1));
    apply(v(0,0,0,0,1,1,MODE_ONESHOT,2,0, 2,1,1,0));

    // Clear beats load; then load beats a terminal tick; limit 0 wraps every tick
    apply(v(0,1,1,16'h00AA,1,1,MODE_WRAP,0,0, 0,0,0,1));
    apply(v(0,0,1,16'h00AA,1,1,MODE_WRAP,0,0, 16'h00AA,0,0,1));
    apply(v(0,0,0,0,1,1,MODE_WRAP,0,0, 0,1,1,1));
    apply(v(0,0,0,0,1,1,MODE_WRAP,0,0, 0,1,1,1));

    // Reset mid-count with p=2 and overflow set; full prescale period afterwards
    apply(v(0,0,1,16'h1234,1,1,MODE_WRAP,16'hFFFF,3, 16'h1234,0,1,1));
    apply(v(0,0,0,0,1,1,MODE_WRAP,16'hFFFF,3, 16'h1234,0,1,1));
    apply(v(0,0,0,0,1,1,MODE_WRAP,16'hFFFF,3, 16'h1234,0,1,1));
    apply(v(1,0,0,0,1,1,MODE_WRAP,16'hFFFF,3, 0,0,0,1));
    for (int i = 0; i < 3; i++) apply(v(0,0,0,0,1,1,MODE_WRAP,16'hFFFF,3, 0,0,0,1));
    apply(v(0,0,0,0,1,1,MODE_WRAP,16'hFFFF,3, 1,0,0,1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
